key_conditioner: RTL and testbench
==================================

# key_conditioner

Input conditioning stage for the calculator's push-buttons. It sits between the raw DE10-Lite KEY pins and the stage/counter/operation logic that consumes `key0`/`key1`. Each channel gets:
- a two-flop synchronizer;
- a consecutive-sample debouncer;
- clean single-cycle press, release and long-press pulses plus a debounced level.

The downstream blocks then see exactly one event per physical action.

## Interface
Parameters:
- `N_KEYS`, 2: number of independent key channels.
- `DEBOUNCE_CYCLES`, 500000: consecutive stable cycles required to accept a level change (10 ms at 50 MHz). Must be ≥ 2.
- `LONG_CYCLES`, 50000000: cycles a key must stay debounced-pressed before `long_press` fires (1 s). Must be > `DEBOUNCE_CYCLES`.
- `REPEAT_CYCLES`, 10000000: auto-repeat period, used only with `KEY_AUTOREPEAT_EN`.

Ports:
- `CLK` in 1: system clock (50 MHz board clock).
- `reset` in 1: synchronous, active-high reset.
- `key_n` in `N_KEYS`: raw keys, active low, asynchronous to `CLK`, bouncy.
- `level` out `N_KEYS`: debounced key state, 1 = pressed.
- `press` out `N_KEYS`: one-cycle pulse on each accepted press.
- `release` out `N_KEYS`: one-cycle pulse on each accepted release.
- `long_press` out `N_KEYS`: one-cycle pulse once per press, after `LONG_CYCLES` held.
- `repeat` out `N_KEYS`: one-cycle auto-repeat pulses. Tied 0 without the macro.

## Operation
- **Channel independence:** all logic is per channel and independent. Pulses on different channels may coincide in the same cycle.
- **Synchronizer:** two flops, reset value 1 (released). The debouncer sees only the second flop output, `s`.
- **Per-channel FSM states:**
  - IDLE: `level` = 0, counter cleared.
  - PRESS_WAIT: `s` = 0 seen; counter increments each cycle `s` stays 0. If `s` returns to 1 → IDLE and the counter clears (bounce rejected, no output). When the counter reaches `DEBOUNCE_CYCLES` → HELD.
  - HELD: `level` = 1, hold counter running. When `s` = 1 → RELEASE_WAIT.
  - RELEASE_WAIT: mirror of PRESS_WAIT. If `s` returns to 0 → HELD (the hold counter is not cleared). When the count completes → IDLE.
- **Press/release pulses:**
  - The IDLE→HELD transition sets `level` = 1 and pulses `press` in the same cycle.
  - The RELEASE_WAIT→IDLE transition clears `level` and pulses `release` in the same cycle.
- **Long press:**
  - The hold counter counts from HELD entry.
  - `long_press` pulses once, when the counter equals `LONG_CYCLES`. The counter then saturates, so there is no second pulse for the same press.
- **Counter widths:** counters are `$clog2(max+1)` bits. There is no wrap-around; each counter saturates or clears.
- **All outputs are registered.**

## Timing
- **Reset values:** `level` = 0, `press` = `release` = `long_press` = `repeat` = 0. FSMs go to IDLE, synchronizers to 1. Counters clear.
- **Press latency:** `key_n` first sampled low at edge 0, stable thereafter → `s` low after edge 2 → `level` rises and `press` is high in the cycle following edge 2+`DEBOUNCE_CYCLES`. Latency is constant.
- **Release latency:** same as press latency, measured from `key_n` going high.
- **Long-press timing:** `long_press` is high exactly `LONG_CYCLES` cycles after the `press` cycle.
- **Pulse width:** every pulse is exactly one cycle wide.
- **Bounce rejection:** any glitch or bounce shorter than `DEBOUNCE_CYCLES` cycles (after synchronization) produces no output change.
- **Reset mid-operation:** all state is discarded immediately with no pulses. If the key is still held when `reset` deasserts, a fresh debounce runs and `press` fires `DEBOUNCE_CYCLES`+2 cycles later.
- **Release before long:** a release accepted before `LONG_CYCLES` means `long_press` never fires for that press.

## Configuration
- **`KEY_AUTOREPEAT_EN` defined:**
  - After `long_press`, `repeat` pulses every `REPEAT_CYCLES` cycles while the channel remains in HELD or RELEASE_WAIT.
  - The first `repeat` comes `REPEAT_CYCLES` after `long_press`.
  - The repeat counter clears on IDLE entry.
- **`KEY_AUTOREPEAT_EN` undefined:**
  - `repeat` is constant 0.
  - The repeat counter and its logic are not synthesized.

## Test plan
Benches use `DEBOUNCE_CYCLES`=4, `LONG_CYCLES`=20, `REPEAT_CYCLES`=5.
- **Clean press:** hold `key_n[0]`=0 from cycle 0 → `press[0]`=1 only in cycle 6 and `level[0]`=1 from cycle 6. `key_n[0]`=1 at cycle 30 → `release[0]` in cycle 36.
- **Bounce rejection:** `key_n[0]` toggles 0/1 every 2 cycles for 40 cycles, then stays 1 → no pulses, `level[0]`=0 throughout.
- **Long press (macro off):** hold `key_n[1]`=0 for 60 cycles → `press[1]` at cycle 6, `long_press[1]` at cycle 26 only once, `repeat` always 0.
- **Auto-repeat (macro on):** same stimulus as the long-press scenario → `repeat[1]` in cycles 31, 36, 41… until release is accepted.
- **Simultaneous keys:** both keys pressed at cycle 0 → `press` = 2'b11 in cycle 6. Release key0 at cycle 10 → `release[0]` in cycle 16 while `level[1]` stays 1.
- **Reset mid-press:** key0 held; `reset` high in cycles 8–9 → all outputs 0 in cycle 9. `press[0]` fires again in cycle 16.

Source files
------------

// File: rtl/key_conditioner.sv
// Push-button conditioner: 2-flop sync, consecutive-sample debounce, press/release/long pulses.
// Optional auto-repeat via `define KEY_AUTOREPEAT_EN; ports release_pulse/repeat_pulse avoid SV keywords.
module key_conditioner #(
    parameter int unsigned N_KEYS          = 2,
    parameter int unsigned DEBOUNCE_CYCLES = 500000,
    parameter int unsigned LONG_CYCLES     = 50000000,
    parameter int unsigned REPEAT_CYCLES   = 10000000
) (
    input  logic              CLK,
    input  logic              reset,
    input  logic [N_KEYS-1:0] key_n,
    output logic [N_KEYS-1:0] level,
    output logic [N_KEYS-1:0] press,
    output logic [N_KEYS-1:0] release_pulse,
    output logic [N_KEYS-1:0] long_press,
    output logic [N_KEYS-1:0] repeat_pulse
);

    localparam int unsigned DB_W   = $clog2(DEBOUNCE_CYCLES + 1);
    localparam int unsigned HOLD_W = $clog2(LONG_CYCLES + 1);

    localparam logic [DB_W-1:0]   DB_MAX   = DB_W'(DEBOUNCE_CYCLES);
    localparam logic [DB_W-1:0]   DB_ONE   = DB_W'(1);
    localparam logic [HOLD_W-1:0] HOLD_MAX = HOLD_W'(LONG_CYCLES);
    localparam logic [HOLD_W-1:0] HOLD_PRE = HOLD_W'(LONG_CYCLES - 1);
    localparam logic [HOLD_W-1:0] HOLD_ONE = HOLD_W'(1);

    if (DEBOUNCE_CYCLES < 2 || LONG_CYCLES <= DEBOUNCE_CYCLES || REPEAT_CYCLES < 1)
    begin : g_bad_params
        $error("key_conditioner: invalid cycle parameters");
    end

    typedef enum logic [1:0] {
        IDLE,
        PRESS_WAIT,
        HELD,
        RELEASE_WAIT
    } state_t;

    for (genvar g = 0; g < N_KEYS; g++) begin : g_chan
        logic              sync1;
        logic              s;
        state_t            state;
        logic [DB_W-1:0]   db_cnt;
        logic [HOLD_W-1:0] hold_cnt;
        logic              hold_sat;
        logic              long_hit;
        logic              release_done;
        logic              level_r;
        logic              press_r;
        logic              release_r;
        logic              long_r;

        always_ff @(posedge CLK) begin
            if (reset) begin
                sync1 <= 1'b1;
                s     <= 1'b1;
            end else begin
                sync1 <= key_n[g];
                s     <= sync1;
            end
        end

        assign hold_sat     = (hold_cnt == HOLD_MAX);
        assign long_hit     = (hold_cnt == HOLD_PRE);
        assign release_done = (state == RELEASE_WAIT) && s && (db_cnt == DB_MAX);

        // Hold counter keeps running through release bounces; it only clears in IDLE.
        always_ff @(posedge CLK) begin
            if (reset) begin
                state     <= IDLE;
                db_cnt    <= '0;
                hold_cnt  <= '0;
                level_r   <= 1'b0;
                press_r   <= 1'b0;
                release_r <= 1'b0;
                long_r    <= 1'b0;
            end else begin
                press_r   <= 1'b0;
                release_r <= 1'b0;
                long_r    <= 1'b0;
                case (state)
                    IDLE: begin
                        hold_cnt <= '0;
                        if (!s) begin
                            state  <= PRESS_WAIT;
                            db_cnt <= DB_ONE;
                        end else begin
                            db_cnt <= '0;
                        end
                    end
                    PRESS_WAIT: begin
                        if (s) begin
                            state  <= IDLE;
                            db_cnt <= '0;
                        end else if (db_cnt == DB_MAX) begin
                            state    <= HELD;
                            db_cnt   <= '0;
                            hold_cnt <= '0;
                            level_r  <= 1'b1;
                            press_r  <= 1'b1;
                        end else begin
                            db_cnt <= db_cnt + DB_ONE;
                        end
                    end
                    HELD: begin
                        if (s) begin
                            state  <= RELEASE_WAIT;
                            db_cnt <= DB_ONE;
                        end
                        if (!hold_sat) begin
                            hold_cnt <= hold_cnt + HOLD_ONE;
                            long_r   <= long_hit;
                        end
                    end
                    RELEASE_WAIT: begin
                        if (!s) begin
                            state  <= HELD;
                            db_cnt <= '0;
                            if (!hold_sat) begin
                                hold_cnt <= hold_cnt + HOLD_ONE;
                                long_r   <= long_hit;
                            end
                        end else if (db_cnt == DB_MAX) begin
                            state     <= IDLE;
                            db_cnt    <= '0;
                            hold_cnt  <= '0;
                            level_r   <= 1'b0;
                            release_r <= 1'b1;
                        end else begin
                            db_cnt <= db_cnt + DB_ONE;
                            if (!hold_sat) begin
                                hold_cnt <= hold_cnt + HOLD_ONE;
                                long_r   <= long_hit;
                            end
                        end
                    end
                    default: begin
                        state  <= IDLE;
                        db_cnt <= '0;
                    end
                endcase
            end
        end

        assign level[g]         = level_r;
        assign press[g]         = press_r;
        assign release_pulse[g] = release_r;
        assign long_press[g]    = long_r;

`ifdef KEY_AUTOREPEAT_EN
        localparam int unsigned REP_W = $clog2(REPEAT_CYCLES + 1);
        localparam logic [REP_W-1:0] REP_LAST = REP_W'(REPEAT_CYCLES - 1);
        localparam logic [REP_W-1:0] REP_ONE  = REP_W'(1);

        logic [REP_W-1:0] rep_cnt;
        logic             rep_r;

        // Saturated hold counter marks "long press already fired"; repeats start from there.
        always_ff @(posedge CLK) begin
            if (reset) begin
                rep_cnt <= '0;
                rep_r   <= 1'b0;
            end else begin
                rep_r <= 1'b0;
                if (state == IDLE || state == PRESS_WAIT || release_done) begin
                    rep_cnt <= '0;
                end else if (hold_sat) begin
                    if (rep_cnt == REP_LAST) begin
                        rep_cnt <= '0;
                        rep_r   <= 1'b1;
                    end else begin
                        rep_cnt <= rep_cnt + REP_ONE;
                    end
                end
            end
        end

        assign repeat_pulse[g] = rep_r;
`else
        assign repeat_pulse[g] = 1'b0;
`endif
    end

endmodule

// File: tb/tb_key_conditioner.sv
// Bench for key_conditioner: directed test-plan scenarios plus randomized key/reset traffic,
// all outputs compared every cycle against a run-length reference model.
module tb_key_conditioner;

    localparam int D = 4;
    localparam int L = 20;
    localparam int R = 5;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic [1:0] key_n = 2'b11;
    logic [1:0] level, press, release_pulse, long_press, repeat_pulse;

    key_conditioner #(
        .N_KEYS         (2),
        .DEBOUNCE_CYCLES(D),
        .LONG_CYCLES    (L),
        .REPEAT_CYCLES  (R)
    ) dut (
        .CLK          (clk),
        .reset        (reset),
        .key_n        (key_n),
        .level        (level),
        .press        (press),
        .release_pulse(release_pulse),
        .long_press   (long_press),
        .repeat_pulse (repeat_pulse)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_pass   = 0;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %0d expected %0d (t=%0t)", tag, got, exp, $time);
    endtask

    // Reference model: level flips once D+1 consecutive debouncer samples disagree with it.
    bit         m_ff1[2], m_ff2[2], m_lvl[2];
    int         m_streak[2], m_ptime[2];
    int         t = 0;
    logic [1:0] e_level, e_press, e_rel, e_long, e_rep;

    task automatic model_edge(input logic r, input logic [1:0] k);
        bit smp;
        int age;
        t++;
        e_press = '0; e_rel = '0; e_long = '0; e_rep = '0;
        for (int ch = 0; ch < 2; ch++) begin
            if (r) begin
                m_ff1[ch] = 1'b1; m_ff2[ch] = 1'b1; m_lvl[ch] = 1'b0; m_streak[ch] = 0;
            end else begin
                smp = m_ff2[ch];
                m_ff2[ch] = m_ff1[ch];
                m_ff1[ch] = k[ch];
                if ((!smp) != m_lvl[ch]) m_streak[ch]++;
                else m_streak[ch] = 0;
                if (m_streak[ch] == D + 1) begin
                    m_streak[ch] = 0;
                    m_lvl[ch] = !m_lvl[ch];
                    if (m_lvl[ch]) begin
                        e_press[ch] = 1'b1;
                        m_ptime[ch] = t;
                    end else begin
                        e_rel[ch] = 1'b1;
                    end
                end else if (m_lvl[ch]) begin
                    age = t - m_ptime[ch];
                    e_long[ch] = (age == L);
`ifdef KEY_AUTOREPEAT_EN
                    e_rep[ch] = (age > L) && ((age - L) % R == 0);
`endif
                end
            end
            e_level[ch] = m_lvl[ch];
        end
    endtask

    // Per-scenario event log, indexed by cycle number within the scenario.
    int cyc;
    int n_press[2], n_rel[2], n_long[2], n_rep[2];
    int first_press[2], last_press[2], first_rel[2], first_long[2], first_rep[2];

    task automatic step(input logic r, input logic [1:0] k);
        reset = r;
        key_n = k;
        @(posedge clk);
        model_edge(r, k);
        @(negedge clk);
        check_eq("level", 32'(level), 32'(e_level));
        check_eq("press", 32'(press), 32'(e_press));
        check_eq("release", 32'(release_pulse), 32'(e_rel));
        check_eq("long_press", 32'(long_press), 32'(e_long));
        check_eq("repeat", 32'(repeat_pulse), 32'(e_rep));
        for (int ch = 0; ch < 2; ch++) begin
            if (press[ch]) begin
                if (n_press[ch] == 0) first_press[ch] = cyc;
                last_press[ch] = cyc;
                n_press[ch]++;
            end
            if (release_pulse[ch]) begin
                if (n_rel[ch] == 0) first_rel[ch] = cyc;
                n_rel[ch]++;
            end
            if (long_press[ch]) begin
                if (n_long[ch] == 0) first_long[ch] = cyc;
                n_long[ch]++;
            end
            if (repeat_pulse[ch]) begin
                if (n_rep[ch] == 0) first_rep[ch] = cyc;
                n_rep[ch]++;
            end
        end
        cyc++;
    endtask

    task automatic scn_start();
        step(1'b1, 2'b11);
        step(1'b1, 2'b11);
        cyc = 0;
        for (int ch = 0; ch < 2; ch++) begin
            n_press[ch] = 0; n_rel[ch] = 0; n_long[ch] = 0; n_rep[ch] = 0;
            first_press[ch] = -1; last_press[ch] = -1; first_rel[ch] = -1;
            first_long[ch] = -1; first_rep[ch] = -1;
        end
    endtask

    int         seg_left[2];
    bit         seg_val[2];
    logic [1:0] kn;

    initial begin
        // Clean press/release on key0
        scn_start();
        for (int c = 0; c < 50; c++) step(1'b0, (c < 30) ? 2'b10 : 2'b11);
        check_eq("clean_press_cycle", 32'(first_press[0]), 32'd6);
        check_eq("clean_press_count", 32'(n_press[0]), 32'd1);
        check_eq("clean_release_cycle", 32'(first_rel[0]), 32'd36);

        // Bounce rejection
        scn_start();
        for (int c = 0; c < 50; c++) step(1'b0, (c < 40 && ((c / 2) % 2 == 0)) ? 2'b10 : 2'b11);
        check_eq("bounce_press_count", 32'(n_press[0]), 32'd0);
        check_eq("bounce_release_count", 32'(n_rel[0]), 32'd0);

        // Long press on key1
        scn_start();
        for (int c = 0; c < 80; c++) step(1'b0, (c < 60) ? 2'b01 : 2'b11);
        check_eq("long_press_cycle", 32'(first_press[1]), 32'd6);
        check_eq("long_fire_cycle", 32'(first_long[1]), 32'd26);
        check_eq("long_fire_count", 32'(n_long[1]), 32'd1);
`ifdef KEY_AUTOREPEAT_EN
        check_eq("repeat_first_cycle", 32'(first_rep[1]), 32'd31);
`else
        check_eq("repeat_count", 32'(n_rep[1]), 32'd0);
`endif

        // Simultaneous keys
        scn_start();
        for (int c = 0; c < 30; c++) step(1'b0, (c < 10) ? 2'b00 : 2'b01);
        check_eq("simul_press0_cycle", 32'(first_press[0]), 32'd6);
        check_eq("simul_press1_cycle", 32'(first_press[1]), 32'd6);
        check_eq("simul_release0_cycle", 32'(first_rel[0]), 32'd16);
        check_eq("simul_release1_count", 32'(n_rel[1]), 32'd0);

        // Reset mid-press
        scn_start();
        for (int c = 0; c < 30; c++) step((c == 8 || c == 9), 2'b10);
        check_eq("rst_press_count", 32'(n_press[0]), 32'd2);
        check_eq("rst_repress_cycle", 32'(last_press[0]), 32'd16);
        check_eq("rst_release_count", 32'(n_rel[0]), 32'd0);

        // Randomized traffic: mixes short bounces with long holds, rare resets
        scn_start();
        seg_left[0] = 0; seg_left[1] = 0;
        for (int i = 0; i < 4000; i++) begin
            for (int ch = 0; ch < 2; ch++) begin
                if (seg_left[ch] == 0) begin
                    seg_val[ch]  = 1'($urandom_range(0, 1));
                    seg_left[ch] = ($urandom_range(0, 1) != 0) ? int'($urandom_range(1, 5))
                                                               : int'($urandom_range(6, 40));
                end
                seg_left[ch]--;
                kn[ch] = seg_val[ch];
            end
            step($urandom_range(0, 299) == 0, kn);
        end

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
